// File: rtl/seq_state.sv
// Instruction-cycle sequencer for the Q2 processor: drives the two-phase state lines s0..s3,
// their complements, the write strobe ws and the front-panel halted indication.
module seq_state #(
   parameter int unsigned ALU_BITS = 8
) (
   input  logic       clk,
   input  logic       nreset,
   input  logic       run,
   input  logic       step,
   input  logic [2:0] o,
   input  logic       deref,
   output logic       s0,
   output logic       s1,
   output logic       s2,
   output logic       s3,
   output logic       ns0,
   output logic       ns1,
   output logic       ns2,
   output logic       ns3,
   output logic       ws,
   output logic       halted
);

   typedef enum logic [3:0] {
      StFetch    = 4'b0000,
      StDeref    = 4'b0001,
      StLoad     = 4'b0010,
      StExec     = 4'b0011,
      StAluFirst = 4'b0100,
      StAluRest  = 4'b1000
   } state_e;

   localparam logic [3:0] LastCnt = 4'(ALU_BITS - 1);

   state_e     r_state, w_state_d;
   logic       r_phase, w_phase_d;
   logic [3:0] r_cnt, w_cnt_d;
   logic [2:0] r_op, w_op_d;
   logic       r_pend, w_pend_d;
   logic       r_halted, w_halted_d;
   logic       w_go;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_state  <= StFetch;
         r_phase  <= 1'b0;
         r_cnt    <= 4'd0;
         r_op     <= 3'd0;
         r_pend   <= 1'b0;
         r_halted <= 1'b1;
      end else begin
         r_state  <= w_state_d;
         r_phase  <= w_phase_d;
         r_cnt    <= w_cnt_d;
         r_op     <= w_op_d;
         r_pend   <= w_pend_d;
         r_halted <= w_halted_d;
      end
   end

   always_comb begin
      w_state_d  = r_state;
      w_phase_d  = r_phase;
      w_cnt_d    = r_cnt;
      w_op_d     = r_op;
      w_halted_d = 1'b0;

      // FETCH phase A is the only place the sequencer can wait; leaving it consumes any step.
      w_go     = (r_state == StFetch) && !r_phase && (run || step || r_pend);
      w_pend_d = w_go ? 1'b0 : (r_pend | step);

      if (!r_phase) begin
         if (r_state != StFetch || w_go) w_phase_d = 1'b1;
      end else begin
         w_phase_d = 1'b0;
         w_cnt_d   = 4'd0;
         unique case (r_state)
            StFetch: begin
               w_op_d = o;
               if (deref)      w_state_d = StDeref;
               else if (!o[2]) w_state_d = StLoad;
               else            w_state_d = StExec;
            end
            StDeref:    w_state_d = r_op[2] ? StExec : StLoad;
            StLoad:     w_state_d = StExec;
            StExec:     w_state_d = (r_op[2] && (r_op[1] || r_op[0])) ? StAluFirst : StFetch;
            StAluFirst: begin
               w_state_d = StAluRest;
               w_cnt_d   = 4'd1;
            end
            StAluRest: begin
               if (r_cnt == LastCnt) begin
                  w_state_d = StFetch;
               end else begin
                  w_cnt_d = r_cnt + 4'd1;
               end
            end
            default: w_state_d = StFetch;
         endcase
      end

      // Halted is registered, so on entry to FETCH A it reflects run/pending at that edge.
      if (w_state_d == StFetch && !w_phase_d) begin
         if (r_state == StFetch && !r_phase) w_halted_d = 1'b1;
         else                                w_halted_d = !(run || w_pend_d);
      end
   end

   assign {s3, s2, s1, s0}     = r_state;
   assign {ns3, ns2, ns1, ns0} = ~r_state;
   assign ws                   = r_phase;
   assign halted               = r_halted;

endmodule
